// File: rtl/board_manager.sv
// Playfield occupancy store for the pixel renderer: commits a locked piece,
// collapses full rows one per cycle, and tracks cleared-line totals and game-over.
module board_manager #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                       pixel_clk,
    input  logic                       Reset,
    input  logic                       lock,
    input  logic                       clear_board,
    input  logic [9:0]                 x0,
    input  logic [9:0]                 x1,
    input  logic [9:0]                 x2,
    input  logic [9:0]                 x3,
    input  logic [9:0]                 y0,
    input  logic [9:0]                 y1,
    input  logic [9:0]                 y2,
    input  logic [9:0]                 y3,
    output logic [ROWS-1:0][COLS-1:0]  board,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 lines_cleared,
    output logic [15:0]                total_lines,
    output logic                       game_over
);

    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, WRITE, SCAN, DONE} state_t;

    state_t                     state;
    logic [RW-1:0]              r;
    logic [2:0]                 cnt;
    logic [9:0]                 px [4];
    logic [9:0]                 py [4];
    logic [ROWS-1:0][COLS-1:0]  mask;
    logic                       hit;
    logic [16:0]                sum;

    // Decode the latched cells into a board-shaped mask; out-of-range cells never match.
    always_comb begin
        mask = '0;
        hit  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (py[i] >= 10'(ROWS)) hit = 1'b1;
            for (int unsigned row = 0; row < ROWS; row++) begin
                for (int unsigned col = 0; col < COLS; col++) begin
                    if (py[i] == 10'(row) && px[i] == 10'(col)) mask[row][col] = 1'b1;
                end
            end
        end
        if (|(mask & board)) hit = 1'b1;
        sum = {1'b0, total_lines} + {14'b0, cnt};
    end

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            board         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
            game_over     <= 1'b0;
            r             <= '0;
            cnt           <= '0;
            px            <= '{default: '0};
            py            <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (lock) begin
                        px    <= '{x0, x1, x2, x3};
                        py    <= '{y0, y1, y2, y3};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= WRITE;
                    end else if (clear_board) begin
                        board     <= '0;
                        game_over <= 1'b0;
                    end
                end
                WRITE: begin
                    board <= board | mask;
                    if (hit) game_over <= 1'b1;
                    r     <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    // A full row is collapsed in place and r is held so the dropped row is rechecked.
                    if (&board[r]) begin
                        for (int unsigned i = 0; i < ROWS - 1; i++) begin
                            if (RW'(i) >= r) board[i] <= board[i+1];
                        end
                        board[ROWS-1] <= '0;
                        cnt           <= cnt + 3'd1;
                    end else if (r == RW'(ROWS - 1)) begin
                        done          <= 1'b1;
                        lines_cleared <= cnt;
                        total_lines   <= sum[16] ? 16'hFFFF : sum[15:0];
                        state         <= DONE;
                    end else begin
                        r <= r + RW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_manager.sv
// Randomized and directed bench for board_manager against a row-filtering reference model.
module tb_board_manager;

    typedef logic [199:0] vec_t;

    logic              pixel_clk = 1'b0;
    logic              Reset = 1'b0;
    logic              lock = 1'b0;
    logic              clear_board = 1'b0;
    logic [9:0]        x [4];
    logic [9:0]        y [4];
    logic [19:0][9:0]  board;
    logic              busy;
    logic              done;
    logic [2:0]        lines_cleared;
    logic [15:0]       total_lines;
    logic              game_over;

    always #5 pixel_clk = ~pixel_clk;

    board_manager #(.ROWS(20), .COLS(10)) dut (
        .pixel_clk(pixel_clk), .Reset(Reset), .lock(lock), .clear_board(clear_board),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .board(board), .busy(busy), .done(done), .lines_cleared(lines_cleared),
        .total_lines(total_lines), .game_over(game_over)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: rows as plain words, full rows removed by filtering.
    logic [9:0] mb [20];
    logic [9:0] wb [20];
    logic [9:0] fb [20];
    int         m_total;
    bit         m_go;
    int         mk;
    logic [9:0] lx [4];
    logic [9:0] ly [4];

    function automatic vec_t pk(input logic [9:0] a [20]);
        vec_t v = '0;
        for (int r = 0; r < 20; r++) v[r*10 +: 10] = a[r];
        return v;
    endfunction

    task automatic model_lock();
        int j;
        for (int r = 0; r < 20; r++) wb[r] = mb[r];
        for (int i = 0; i < 4; i++) begin
            int xx = int'(lx[i]);
            int yy = int'(ly[i]);
            if (yy >= 20) m_go = 1'b1;
            else if (xx < 10) begin
                if (mb[yy][xx]) m_go = 1'b1;
                wb[yy][xx] = 1'b1;
            end
        end
        j  = 0;
        mk = 0;
        for (int r = 0; r < 20; r++) begin
            if (wb[r] == 10'h3FF) mk++;
            else begin
                fb[j] = wb[r];
                j++;
            end
        end
        while (j < 20) begin
            fb[j] = '0;
            j++;
        end
    endtask

    task automatic piece(input int xa, input int ya, input int xb, input int yb,
                         input int xc, input int yc, input int xd, input int yd);
        lx[0] = 10'(xa); ly[0] = 10'(ya);
        lx[1] = 10'(xb); ly[1] = 10'(yb);
        lx[2] = 10'(xc); ly[2] = 10'(yc);
        lx[3] = 10'(xd); ly[3] = 10'(yd);
    endtask

    task automatic do_lock(input bit poke);
        int n;
        int dn;
        model_lock();
        @(negedge pixel_clk);
        for (int i = 0; i < 4; i++) begin x[i] = lx[i]; y[i] = ly[i]; end
        lock = 1'b1;
        @(negedge pixel_clk);
        lock = 1'b0;
        for (int i = 0; i < 4; i++) begin x[i] = 10'($urandom); y[i] = 10'($urandom); end
        check("busy_after_E0", vec_t'(busy), vec_t'(1));
        @(negedge pixel_clk);
        check("board_after_write", vec_t'(board), pk(wb));
        check("game_over_write", vec_t'(game_over), vec_t'(m_go));
        n = 1;
        while (n < 40 && done !== 1'b1) begin
            @(negedge pixel_clk);
            n++;
            if (poke && n == 5) lock = 1'b1;
            if (poke && n == 7) lock = 1'b0;
        end
        m_total = (m_total + mk > 65535) ? 65535 : m_total + mk;
        for (int r = 0; r < 20; r++) mb[r] = fb[r];
        check("done_latency", vec_t'(n), vec_t'(21 + mk));
        check("lines_cleared", vec_t'(lines_cleared), vec_t'(mk));
        check("total_lines", vec_t'(total_lines), vec_t'(m_total));
        check("board_final", vec_t'(board), pk(mb));
        check("game_over", vec_t'(game_over), vec_t'(m_go));
        check("busy_in_done", vec_t'(busy), vec_t'(1));
        @(negedge pixel_clk);
        check("done_one_cycle", vec_t'(done), vec_t'(0));
        check("busy_after_done", vec_t'(busy), vec_t'(0));
        if (poke) begin
            dn = 0;
            repeat (30) begin
                @(negedge pixel_clk);
                if (done) dn++;
            end
            check("extra_done", vec_t'(dn), vec_t'(0));
            check("board_after_poke", vec_t'(board), pk(mb));
        end
    endtask

    task automatic do_clear();
        @(negedge pixel_clk);
        clear_board = 1'b1;
        @(negedge pixel_clk);
        clear_board = 1'b0;
        for (int r = 0; r < 20; r++) mb[r] = '0;
        m_go = 1'b0;
        check("clear_board", vec_t'(board), vec_t'(0));
        check("clear_game_over", vec_t'(game_over), vec_t'(0));
        check("clear_total", vec_t'(total_lines), vec_t'(m_total));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_board"}, vec_t'(board), vec_t'(0));
        check({tag, "_busy"}, vec_t'(busy), vec_t'(0));
        check({tag, "_done"}, vec_t'(done), vec_t'(0));
        check({tag, "_lines"}, vec_t'(lines_cleared), vec_t'(0));
        check({tag, "_total"}, vec_t'(total_lines), vec_t'(0));
        check({tag, "_game_over"}, vec_t'(game_over), vec_t'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        int sel;
        for (int i = 0; i < 4; i++) begin x[i] = '0; y[i] = '0; end
        for (int r = 0; r < 20; r++) mb[r] = '0;
        m_total = 0;
        m_go    = 1'b0;
        #2 Reset = 1'b1;
        #1 check_reset_values("reset");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        Reset = 1'b0;

        // Single row segment, no clear.
        piece(0, 0, 1, 0, 2, 0, 3, 0);
        do_lock(1'b0);
        check("t1_row0", vec_t'(board[0]), vec_t'(10'h00F));

        // Row 0 preloaded with 3F0 then completed.
        do_clear();
        piece(4, 0, 5, 0, 6, 0, 7, 0); do_lock(1'b0);
        piece(8, 0, 9, 0, 8, 0, 9, 0); do_lock(1'b0);
        check("t2_preload", vec_t'(board[0]), vec_t'(10'h3F0));
        piece(0, 0, 1, 0, 2, 0, 3, 0); do_lock(1'b0);
        check("t2_board", vec_t'(board), vec_t'(0));
        check("t2_total", vec_t'(total_lines), vec_t'(1));

        // Four-row clear with a single cell above dropping to row 0.
        do_clear();
        for (int r = 0; r < 4; r++) begin
            piece(1, r, 2, r, 3, r, 4, r); do_lock(1'b0);
            piece(5, r, 6, r, 7, r, 8, r); do_lock(1'b0);
            piece(9, r, 9, r, 9, r, 9, r); do_lock(1'b0);
        end
        piece(0, 4, 0, 4, 0, 4, 0, 4); do_lock(1'b0);
        piece(0, 0, 0, 1, 0, 2, 0, 3); do_lock(1'b0);
        check("t3_row0", vec_t'(board[0]), vec_t'(10'h001));
        check("t3_lines", vec_t'(lines_cleared), vec_t'(4));

        // Off-top cell sets sticky game_over; clear_board wipes it.
        do_clear();
        piece(0, 0, 1, 0, 2, 20, 3, 0); do_lock(1'b0);
        check("t4_go", vec_t'(game_over), vec_t'(1));
        piece(0, 5, 1, 5, 2, 5, 3, 5); do_lock(1'b0);
        check("t4_go_sticky", vec_t'(game_over), vec_t'(1));
        do_clear();

        // lock while busy is ignored.
        piece(4, 1, 5, 1, 6, 1, 7, 1);
        do_lock(1'b1);

        // Reset during SCAN aborts without done.
        @(negedge pixel_clk);
        for (int i = 0; i < 4; i++) begin x[i] = 10'(i); y[i] = 10'd7; end
        lock = 1'b1;
        @(negedge pixel_clk);
        lock = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        Reset = 1'b1;
        #1 check_reset_values("abort");
        @(negedge pixel_clk);
        Reset = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge pixel_clk);
            if (done) dn++;
        end
        check("abort_no_done", vec_t'(dn), vec_t'(0));
        for (int r = 0; r < 20; r++) mb[r] = '0;
        m_total = 0;
        m_go    = 1'b0;

        // Random pieces near the floor so rows complete often.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                sel   = int'($urandom_range(0, 15));
                lx[i] = (sel == 0) ? 10'($urandom_range(10, 1023)) : 10'($urandom_range(0, 9));
                ly[i] = (sel == 1) ? 10'($urandom_range(20, 1023)) : 10'($urandom_range(0, 2));
            end
            do_lock(t % 7 == 3);
            if (t % 10 == 9) do_clear();
        end

        // Saturation of the running total.
        do_clear();
        for (int r = 0; r < 3; r++) begin
            piece(1, r, 2, r, 3, r, 4, r); do_lock(1'b0);
            piece(5, r, 6, r, 7, r, 8, r); do_lock(1'b0);
            piece(9, r, 9, r, 9, r, 9, r); do_lock(1'b0);
        end
        @(negedge pixel_clk);
        force dut.total_lines = 16'hFFFE;
        @(negedge pixel_clk);
        release dut.total_lines;
        #1 check("force_total", vec_t'(total_lines), vec_t'(16'hFFFE));
        m_total = 65534;
        piece(0, 0, 0, 1, 0, 2, 0, 2); do_lock(1'b0);
        check("sat_total", vec_t'(total_lines), vec_t'(16'hFFFF));
        check("sat_lines", vec_t'(lines_cleared), vec_t'(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_manager.md
# board_manager

Owns the 20×10 playfield occupancy array that the pixel renderer reads each frame. On a lock request it commits the four cells of the falling piece, scans for full rows, collapses them one at a time, and reports cleared-line counts and game-over. Runs on the pixel clock, so the renderer reads `board` with no clock crossing.

## Interface
- `ROWS`, 20: playfield height; row 0 is the bottom row.
- `COLS`, 10: playfield width; bit `x` of a row is column `x`.
- `pixel_clk`  in  1: system clock.
- `Reset`  in  1: asynchronous, active-high reset.
- `lock`  in  1: commit-piece request; sampled only in IDLE.
- `clear_board`  in  1: synchronous wipe; sampled only in IDLE; lower priority than `lock`.
- `x0..x3`  in  10 each: piece cell columns, game coordinates.
- `y0..y3`  in  10 each: piece cell rows, game coordinates.
- `board`  out  20×10: occupancy; `board[y][x]`=1 means the cell is filled.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse at the end of a lock sequence.
- `lines_cleared`  out  3: rows removed by the last lock, range 0–4; holds until the next `done`.
- `total_lines`  out  16: running total of cleared rows; saturates at 16'hFFFF.
- `game_over`  out  1: sticky; cleared only by `Reset` or `clear_board`.

## Operation
- States: IDLE, WRITE, SCAN, DONE.
- IDLE
  - `lock`=1: latch x0..x3 and y0..y3, zero the line counter, go to WRITE.
  - Otherwise `clear_board`=1: zero `board` and `game_over`, stay in IDLE. `total_lines` is not affected.
- WRITE (one cycle)
  - For each cell with x<COLS and y<ROWS, set `board[y][x]`. This is an OR, so duplicate cells are harmless.
  - A cell with x≥COLS is dropped silently.
  - A cell with y≥ROWS is dropped and sets `game_over`.
  - A cell whose target bit was already 1 before this write sets `game_over`.
  - Set row index r=0, go to SCAN.
- SCAN (one row per cycle)
  - If `board[r]`==all-ones:
    - Rows r..ROWS-2 take the contents of the row above; row ROWS-1 becomes 0. All rows shift in a single cycle.
    - Line counter +1.
    - r stays the same, because the row that dropped into r must be checked.
  - Otherwise r+1.
  - Leave for DONE when r=ROWS-1 and that row is not full.
  - Row ROWS-1 is checked like any other row; if it is full it is cleared to 0 and r stays at ROWS-1.
- DONE (one cycle)
  - `done`=1.
  - `lines_cleared` ← counter.
  - `total_lines` ← min(`total_lines` + counter, 16'hFFFF), computed with a 17-bit add then clamped.
  - Go to IDLE.
- `lock` asserted while `busy`=1 is ignored. It is not queued, and neither is `clear_board`.
- Piece coordinates may change after the latch cycle; only the latched values are used.
- `game_over` does not block further locks; upstream logic is responsible for gating.

## Timing
- Reset, asynchronous: `board`=0, state IDLE, `busy`=0, `done`=0, `lines_cleared`=0, `total_lines`=0, `game_over`=0, r=0.
- `Reset` asserted mid-sequence aborts the sequence immediately. No `done` is generated, and all outputs take their reset values.
- Edge E0 samples `lock`. `busy` is high from after E0 until the cycle after the `done` pulse.
- `board` updates are registered:
  - piece cells are visible after E1;
  - each collapse is visible after its SCAN edge.
- Lock-to-`done` latency with k rows cleared: `done` is high during the cycle following edge E(21+k). For k=0 that is 21 cycles after the lock was sampled.
- `lines_cleared`, `total_lines` and `game_over` are registered outputs. `lines_cleared` and `total_lines` change only on the `done` cycle. `game_over` is set at the WRITE edge.
- The renderer may sample `board` mid-sequence and will see intermediate collapses. This is accepted: a sequence takes at most 25 cycles, which is far shorter than one frame.

## Test plan
- Reset, then lock cells (0,0),(1,0),(2,0),(3,0) → after E1 `board[0]`=10'h00F; `done` in cycle 21; `lines_cleared`=0; `game_over`=0.
- Preload row 0 = 10'h3F0 via prior locks, then lock (0,0),(1,0),(2,0),(3,0) → row 0 full and cleared; `board`=0; `done` at 21+1; `lines_cleared`=1; `total_lines`=1.
- Preload rows 0–3 = 10'h3FE and row 4 = 10'h001, then lock a vertical I-piece at x=0, y=0..3 → 4 rows cleared; `board[0]`=10'h001 with all other rows 0; `lines_cleared`=4; `done` at cycle 25.
- Lock a cell at y=20 → that cell is dropped; `game_over`=1 and stays 1 across a later clean lock; `clear_board` in IDLE → `board`=0 and `game_over`=0.
- Assert `lock` while `busy`=1 → no effect, exactly one `done`. Assert `Reset` during SCAN → immediate reset values and no `done`.
- Force `total_lines`=16'hFFFE, then clear 3 rows → `total_lines`=16'hFFFF (saturated).
